// File: rtl/common_pkg.sv
// Shared register-file identifiers and fetch sequencer state encoding.
package common_pkg;

    localparam int unsigned REG_ID_W = 2;

    typedef enum logic [REG_ID_W-1:0] {
        R_IP  = 2'd0,
        R_IR1 = 2'd1,
        R_IR2 = 2'd2,
        R_ZR  = 2'd3
    } reg_id_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH1 = 3'd1,
        INC1   = 3'd2,
        FETCH2 = 3'd3,
        INC2   = 3'd4,
        ISSUE  = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads one or two words at IP into IR1/IR2 through
// the register file, bumps IP after each word and hands the instruction to execute.
module fetch_sequencer
    import common_pkg::*;
#(
    parameter int unsigned EXT_BIT = 15,
    parameter int unsigned W       = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_run,
    input  logic         i_redirect,
    input  logic [W-1:0] i_redirect_addr,
    output logic         o_mem_req,
    input  logic         i_mem_ack,
    input  logic [W-1:0] i_mem_data,
    output reg_id_e      o_ab_addr,
    output reg_id_e      o_s1_addr,
    input  logic [W-1:0] i_s1_data,
    output logic         o_wr_en,
    output reg_id_e      o_dest_addr,
    output logic [W-1:0] o_dest_data,
    output logic         o_insn_valid,
    output logic [1:0]   o_insn_len,
    input  logic         i_insn_ready,
    output logic         o_busy
);

    fetch_state_e state_q, state_d;
    logic         ext_q, ext_d;
    logic [1:0]   len_d;

    // State, extension flag and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ext_q      <= 1'b0;
            o_busy     <= 1'b0;
            o_insn_len <= 2'd0;
        end else begin
            state_q    <= state_d;
            ext_q      <= ext_d;
            o_busy     <= (state_d != IDLE);
            o_insn_len <= len_d;
        end
    end

    // Next-state and register-file/memory control decode.
    always_comb begin
        state_d      = state_q;
        ext_d        = ext_q;
        o_wr_en      = 1'b0;
        o_dest_addr  = R_ZR;
        o_dest_data  = '0;
        o_mem_req    = 1'b0;
        o_insn_valid = 1'b0;
        o_ab_addr    = R_ZR;
        o_s1_addr    = R_ZR;

        if (i_redirect) begin
            o_wr_en     = 1'b1;
            o_dest_addr = R_IP;
            o_dest_data = i_redirect_addr;
            ext_d       = 1'b0;
            state_d     = i_run ? FETCH1 : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_run) state_d = FETCH1;
                end
                FETCH1: begin
                    o_ab_addr = R_IP;
                    o_mem_req = 1'b1;
                    if (i_mem_ack) begin
                        o_wr_en     = 1'b1;
                        o_dest_addr = R_IR1;
                        o_dest_data = i_mem_data;
                        ext_d       = i_mem_data[EXT_BIT];
                        state_d     = INC1;
                    end
                end
                INC1: begin
                    o_s1_addr   = R_IP;
                    o_wr_en     = 1'b1;
                    o_dest_addr = R_IP;
                    o_dest_data = i_s1_data + W'(1);
                    state_d     = ext_q ? FETCH2 : ISSUE;
                end
                FETCH2: begin
                    o_ab_addr = R_IP;
                    o_mem_req = 1'b1;
                    if (i_mem_ack) begin
                        o_wr_en     = 1'b1;
                        o_dest_addr = R_IR2;
                        o_dest_data = i_mem_data;
                        state_d     = INC2;
                    end
                end
                INC2: begin
                    o_s1_addr   = R_IP;
                    o_wr_en     = 1'b1;
                    o_dest_addr = R_IP;
                    o_dest_data = i_s1_data + W'(1);
                    state_d     = ISSUE;
                end
                ISSUE: begin
                    o_insn_valid = 1'b1;
                    if (i_insn_ready) state_d = i_run ? FETCH1 : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Reset overrides every side effect in the cycle it is asserted.
        if (i_rst) begin
            o_wr_en      = 1'b0;
            o_dest_addr  = R_ZR;
            o_mem_req    = 1'b0;
            o_insn_valid = 1'b0;
        end

        len_d = (state_d == ISSUE) ? (ext_d ? 2'd2 : 2'd1) : 2'd0;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural register file and memory.
module tb_fetch_sequencer;
    import common_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_run = 1'b0;
    logic        i_redirect = 1'b0;
    logic [15:0] i_redirect_addr = 16'h0;
    logic        o_mem_req;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    reg_id_e     o_ab_addr, o_s1_addr, o_dest_addr;
    logic [15:0] i_s1_data;
    logic        o_wr_en;
    logic [15:0] o_dest_data;
    logic        o_insn_valid;
    logic [1:0]  o_insn_len;
    logic        i_insn_ready = 1'b0;
    logic        o_busy;

    int total = 0;
    int bad = 0;

    fetch_sequencer #(.EXT_BIT(15), .W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run),
        .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
        .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_ab_addr(o_ab_addr), .o_s1_addr(o_s1_addr), .i_s1_data(i_s1_data),
        .o_wr_en(o_wr_en), .o_dest_addr(o_dest_addr), .o_dest_data(o_dest_data),
        .o_insn_valid(o_insn_valid), .o_insn_len(o_insn_len),
        .i_insn_ready(i_insn_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Register file model
    logic [15:0] rf_ip = 16'h0, rf_ir1 = 16'h0, rf_ir2 = 16'h0;
    int          wr_cnt = 0, ip_wr_cnt = 0;
    logic        preload_en = 1'b0;
    logic [15:0] preload_val = 16'h0;
    logic [15:0] ab_val;

    always @(posedge i_clk) begin
        if (preload_en) rf_ip <= preload_val;
        else if (o_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            case (o_dest_addr)
                R_IP:    begin rf_ip <= o_dest_data; ip_wr_cnt <= ip_wr_cnt + 1; end
                R_IR1:   rf_ir1 <= o_dest_data;
                R_IR2:   rf_ir2 <= o_dest_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (o_s1_addr)
            R_IP:    i_s1_data = rf_ip;
            R_IR1:   i_s1_data = rf_ir1;
            R_IR2:   i_s1_data = rf_ir2;
            default: i_s1_data = 16'h0;
        endcase
        case (o_ab_addr)
            R_IP:    ab_val = rf_ip;
            R_IR1:   ab_val = rf_ir1;
            R_IR2:   ab_val = rf_ir2;
            default: ab_val = 16'h0;
        endcase
    end

    // Memory model: address-matched table, ack after mem_wait request cycles
    logic [15:0] mem_a [4];
    logic [15:0] mem_d [4];
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic        ack_force = 1'b0;

    always_comb begin
        i_mem_data = 16'hDEAD;
        for (int k = 0; k < 4; k++)
            if (mem_a[k] == ab_val) i_mem_data = mem_d[k];
    end

    assign i_mem_ack = ack_force | (o_mem_req && (wait_cnt >= mem_wait));

    always @(posedge i_clk) begin
        if (o_mem_req && !i_mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic setup(input logic [15:0] ip, input logic [15:0] a0, input logic [15:0] d0,
                         input logic [15:0] a1, input logic [15:0] d1);
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = 16'hAAAA;
            mem_d[k] = 16'h0;
        end
        mem_a[0] = a0; mem_d[0] = d0;
        mem_a[1] = a1; mem_d[1] = d1;
        @(negedge i_clk);
        preload_en = 1'b1;
        preload_val = ip;
        @(negedge i_clk);
        preload_en = 1'b0;
    endtask

    // Called #1 after a negedge inside FETCH1; cyc counts FETCH1 as cycle 1.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_insn_valid && cyc < 20) begin
            @(negedge i_clk);
            #1;
            cyc++;
        end
        if (!o_insn_valid) cyc = -1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        total++; if (o_wr_en !== 1'b0 || o_mem_req !== 1'b0 || o_insn_valid !== 1'b0) begin
            bad++; $display("FAIL reset_strobes got=%b%b%b exp=000", o_wr_en, o_mem_req, o_insn_valid); end
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_insn_len !== 2'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", o_insn_len); end
        total++; if (o_ab_addr !== R_ZR || o_s1_addr !== R_ZR || o_dest_addr !== R_ZR) begin
            bad++; $display("FAIL reset_addrs got=%0d/%0d/%0d exp=3/3/3", o_ab_addr, o_s1_addr, o_dest_addr); end
    endtask

    task automatic test_one_word();
        int cyc;
        setup(16'h0010, 16'h0010, 16'h1234, 16'hAAAA, 16'h0);
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        #1;
        total++; if (o_mem_req !== 1'b1 || o_ab_addr !== R_IP) begin
            bad++; $display("FAIL f1_req got=%b/%0d exp=1/0", o_mem_req, o_ab_addr); end
        total++; if (o_wr_en !== 1'b1 || o_dest_addr !== R_IR1 || o_dest_data !== 16'h1234) begin
            bad++; $display("FAIL f1_write got=%b/%0d/%h exp=1/1/1234", o_wr_en, o_dest_addr, o_dest_data); end
        @(negedge i_clk);
        #1;
        total++; if (o_s1_addr !== R_IP || o_dest_addr !== R_IP || o_dest_data !== 16'h0011) begin
            bad++; $display("FAIL inc1 got=%0d/%0d/%h exp=0/0/0011", o_s1_addr, o_dest_addr, o_dest_data); end
        @(negedge i_clk);
        #1;
        cyc = 2;
        if (!o_insn_valid) wait_valid(cyc);
        else cyc = 3;
        total++; if (cyc != 3) begin bad++; $display("FAIL one_latency got=%0d exp=3", cyc); end
        total++; if (o_insn_len !== 2'd1) begin bad++; $display("FAIL one_len got=%0d exp=1", o_insn_len); end
        total++; if (rf_ir1 !== 16'h1234 || rf_ip !== 16'h0011) begin
            bad++; $display("FAIL one_regs got=%h/%h exp=1234/0011", rf_ir1, rf_ip); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0 || o_insn_valid !== 1'b0) begin
            bad++; $display("FAIL one_idle got=%b/%b exp=0/0", o_busy, o_insn_valid); end
    endtask

    task automatic test_two_word();
        int cyc;
        setup(16'h0020, 16'h0020, 16'h8001, 16'h0021, 16'hBEEF);
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        #1;
        wait_valid(cyc);
        total++; if (cyc != 5) begin bad++; $display("FAIL two_latency got=%0d exp=5", cyc); end
        total++; if (o_insn_len !== 2'd2) begin bad++; $display("FAIL two_len got=%0d exp=2", o_insn_len); end
        total++; if (rf_ir1 !== 16'h8001 || rf_ir2 !== 16'hBEEF || rf_ip !== 16'h0022) begin
            bad++; $display("FAIL two_regs got=%h/%h/%h exp=8001/beef/0022", rf_ir1, rf_ir2, rf_ip); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        setup(16'hFFFF, 16'hFFFF, 16'h0042, 16'hAAAA, 16'h0);
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        #1;
        wait_valid(cyc);
        total++; if (cyc != 3 || o_insn_len !== 2'd1) begin
            bad++; $display("FAIL wrap_issue got=%0d/%0d exp=3/1", cyc, o_insn_len); end
        total++; if (rf_ip !== 16'h0000 || rf_ir1 !== 16'h0042) begin
            bad++; $display("FAIL wrap_regs got=%h/%h exp=0000/0042", rf_ip, rf_ir1); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
    endtask

    task automatic test_redirect();
        int cyc;
        setup(16'h0030, 16'h0030, 16'h8005, 16'h4000, 16'h2222);
        mem_a[2] = 16'h0031; mem_d[2] = 16'h1111;
        i_run = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        i_redirect = 1'b1;
        i_redirect_addr = 16'h4000;
        ack_force = 1'b1;
        #1;
        total++; if (o_mem_req !== 1'b0 || o_insn_valid !== 1'b0) begin
            bad++; $display("FAIL redir_force got=%b/%b exp=0/0", o_mem_req, o_insn_valid); end
        total++; if (o_wr_en !== 1'b1 || o_dest_addr !== R_IP || o_dest_data !== 16'h4000) begin
            bad++; $display("FAIL redir_write got=%b/%0d/%h exp=1/0/4000", o_wr_en, o_dest_addr, o_dest_data); end
        @(negedge i_clk);
        i_redirect = 1'b0;
        ack_force = 1'b0;
        i_run = 1'b0;
        #1;
        total++; if (o_mem_req !== 1'b1 || o_ab_addr !== R_IP) begin
            bad++; $display("FAIL redir_refetch got=%b/%0d exp=1/0", o_mem_req, o_ab_addr); end
        total++; if (rf_ip !== 16'h4000 || rf_ir2 !== 16'hBEEF) begin
            bad++; $display("FAIL redir_regs got=%h/%h exp=4000/beef", rf_ip, rf_ir2); end
        wait_valid(cyc);
        total++; if (cyc != 3 || o_insn_len !== 2'd1 || rf_ir1 !== 16'h2222) begin
            bad++; $display("FAIL redir_issue got=%0d/%0d/%h exp=3/1/2222", cyc, o_insn_len, rf_ir1); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
    endtask

    task automatic test_stall();
        int wr0;
        setup(16'h0050, 16'h0050, 16'h0777, 16'hAAAA, 16'h0);
        mem_wait = 3;
        wr0 = wr_cnt;
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (o_mem_req !== 1'b1 || o_wr_en !== 1'b0) begin
                bad++; $display("FAIL stall_wait%0d got=%b/%b exp=1/0", c, o_mem_req, o_wr_en); end
            @(negedge i_clk);
        end
        #1;
        total++; if (o_wr_en !== 1'b1 || o_dest_addr !== R_IR1) begin
            bad++; $display("FAIL stall_ack got=%b/%0d exp=1/1", o_wr_en, o_dest_addr); end
        @(negedge i_clk);
        @(negedge i_clk);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (o_insn_valid !== 1'b1 || o_wr_en !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%b exp=1/0", c, o_insn_valid, o_wr_en); end
            @(negedge i_clk);
        end
        total++; if (wr_cnt - wr0 != 2 || rf_ip !== 16'h0051) begin
            bad++; $display("FAIL stall_writes got=%0d/%h exp=2/0051", wr_cnt - wr0, rf_ip); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
        mem_wait = 0;
    endtask

    task automatic test_reset_mid();
        int ipw;
        setup(16'h0060, 16'h0060, 16'h0101, 16'hAAAA, 16'h0);
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        @(negedge i_clk);
        ipw = ip_wr_cnt;
        i_rst = 1'b1;
        #1;
        total++; if (o_wr_en !== 1'b0 || o_mem_req !== 1'b0) begin
            bad++; $display("FAIL rstmid_strobes got=%b/%b exp=0/0", o_wr_en, o_mem_req); end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0 || o_insn_len !== 2'd0) begin
            bad++; $display("FAIL rstmid_idle got=%b/%0d exp=0/0", o_busy, o_insn_len); end
        total++; if (rf_ip !== 16'h0060 || ip_wr_cnt != ipw) begin
            bad++; $display("FAIL rstmid_ip got=%h/%0d exp=0060/%0d", rf_ip, ip_wr_cnt, ipw); end
        total++; if (o_ab_addr !== R_ZR || o_s1_addr !== R_ZR || o_dest_addr !== R_ZR) begin
            bad++; $display("FAIL rstmid_addrs got=%0d/%0d/%0d exp=3/3/3", o_ab_addr, o_s1_addr, o_dest_addr); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        setup(16'h0070, 16'h0070, 16'h0001, 16'h0071, 16'h0002);
        i_run = 1'b1;
        @(negedge i_clk);
        #1;
        wait_valid(cyc);
        total++; if (cyc != 3 || rf_ir1 !== 16'h0001) begin
            bad++; $display("FAIL b2b_first got=%0d/%h exp=3/0001", cyc, rf_ir1); end
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
        #1;
        total++; if (o_mem_req !== 1'b1 || o_busy !== 1'b1) begin
            bad++; $display("FAIL b2b_refetch got=%b/%b exp=1/1", o_mem_req, o_busy); end
        wait_valid(cyc);
        total++; if (cyc != 3 || rf_ir1 !== 16'h0002 || rf_ip !== 16'h0072) begin
            bad++; $display("FAIL b2b_second got=%0d/%h/%h exp=3/0002/0072", cyc, rf_ir1, rf_ip); end
        i_run = 1'b0;
        i_insn_ready = 1'b1;
        @(negedge i_clk);
        i_insn_ready = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_two_word();
        test_wrap();
        test_redirect();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning): EXT_BIT, 15, bit of the first instruction word that marks a two-word instruction; W, 16, datapath width.
REQ-002 SHALL have one clock and a synchronous, active-high reset, named and ordered as: i_clk  in  1  rising-edge clock; i_rst  in  1  synchronous active-high reset.
REQ-003 SHALL have these remaining ports (name, direction, width, meaning):
 i_run  in  1  keep fetching while high;
 i_redirect  in  1  load IP with new address and abort the current fetch;
 i_redirect_addr  in  W  new IP value;
 o_mem_req  out  1  memory read request, addressed by the register file ab port;
 i_mem_ack  in  1  read data valid this cycle;
 i_mem_data  in  W  read data;
 o_ab_addr  out  reg_id_e  register file ab port select;
 o_s1_addr  out  reg_id_e  register file s1 port select;
 i_s1_data  in  W  register file s1 read data;
 o_wr_en  out  1  register file write enable;
 o_dest_addr  out  reg_id_e  register file write select;
 o_dest_data  out  W  register file write data;
 o_insn_valid  out  1  instruction in IR1/IR2 ready for execute;
 o_insn_len  out  2  1 or 2 words;
 i_insn_ready  in  1  execute consumes the instruction;
 o_busy  out  1  state is not IDLE.

Function
REQ-004 SHALL implement states IDLE, FETCH1, INC1, FETCH2, INC2 and ISSUE.
REQ-005 SHALL drive o_wr_en, o_mem_req and o_insn_valid as combinational decodes of the state and inputs. All other state is registered.
REQ-006 IDLE: SHALL move to FETCH1 on the next edge when i_run=1. Otherwise it stays in IDLE.
REQ-007 FETCH1: SHALL drive o_ab_addr=R_IP and o_mem_req=1, and SHALL wait with no cycle limit for i_mem_ack.
REQ-008 FETCH1 on the i_mem_ack cycle: SHALL write IR1 (o_wr_en=1, o_dest_addr=R_IR1, o_dest_data=i_mem_data), latch i_mem_data[EXT_BIT] as ext, and move to INC1.
REQ-009 INC1: SHALL drive o_s1_addr=R_IP and write IP with i_s1_data+1, modulo 2^W (0xFFFF becomes 0x0000). It then moves to FETCH2 if ext=1, else to ISSUE.
REQ-010 FETCH2 and INC2: SHALL behave as FETCH1 and INC1, except that the fetched word is written to R_IR2, and INC2 always moves to ISSUE.
REQ-011 ISSUE: SHALL assert o_insn_valid=1 with o_insn_len = 2 if ext=1, else 1.
REQ-012 ISSUE on i_insn_ready=1: SHALL move to FETCH1 if i_run=1, else to IDLE. o_insn_valid stays high until ready is seen.
REQ-013 i_run low during FETCH1 through INC2: SHALL complete the current instruction through ISSUE and then go to IDLE. No partial instruction is left.
REQ-014 i_redirect=1 in any state: SHALL take priority over everything else.
REQ-015 On an i_redirect=1 cycle, the block SHALL:
 write IP (o_dest_addr=R_IP, o_dest_data=i_redirect_addr);
 force o_mem_req=0 and o_insn_valid=0;
 discard any coincident i_mem_ack or i_insn_ready;
 clear ext;
 go to FETCH1 if i_run=1, else to IDLE.
REQ-016 SHALL perform at most one register file write per cycle.
REQ-017 SHALL drive o_dest_addr, o_s1_addr and o_ab_addr to R_ZR whenever they are unused.
REQ-018 Latency: a one-word instruction with zero-wait memory SHALL give o_insn_valid 3 cycles after FETCH1 is entered; a two-word instruction SHALL give it 5 cycles after.

Reset
REQ-019 While i_rst=1, the block SHALL force o_wr_en=0, o_mem_req=0 and o_insn_valid=0 combinationally.
REQ-020 At the edge with i_rst=1, the block SHALL set state=IDLE and ext=0. From the next cycle, o_busy=0, o_insn_len=0 and all address outputs are R_ZR.
REQ-021 Reset asserted mid-fetch SHALL abandon the fetch with no write to IP, IR1 or IR2.

Structure
REQ-022 reg_id_e (R_IP, R_IR1, R_IR2, R_ZR) SHALL come from common_pkg. fetch_state_e SHALL be added to common_pkg.
REQ-023 The block SHALL have no sub-module. The +1 incrementer is inline.
REQ-024 The block SHALL connect directly to register_file, with o_dest_addr/o_dest_data/o_wr_en driving i_dest_addr/i_dest_data/i_wr_en.

Verification
REQ-025 With IP=0x0010, memory returning 0x1234, zero-wait ack, and i_run pulsed: IR1=0x1234, IP=0x0011, o_insn_valid high with o_insn_len=1 three cycles after FETCH1.
REQ-026 With IP=0x0020 and memory returning 0x8001 then 0xBEEF: IR1=0x8001, IR2=0xBEEF, IP=0x0022, o_insn_len=2.
REQ-027 With IP=0xFFFF and a one-word instruction: IP wraps to 0x0000.
REQ-028 With i_redirect and addr 0x4000 asserted in the same cycle as i_mem_ack during FETCH2: IR2 is unchanged, IP=0x4000, the next o_mem_req is in FETCH1, and no o_insn_valid is given for the aborted instruction.
REQ-029 With ack delayed 3 cycles and i_insn_ready held low 4 cycles: o_mem_req holds, o_insn_valid holds, and there are no extra writes.
REQ-030 With i_rst pulsed during INC1: no IP write occurs, and the block is in IDLE with o_busy=0 the next cycle.
